// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants and data types for the video path.
package video_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Raw per-pixel timing flags; all-zero means "no sync, blanked".
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } timing_t;

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] first,
                                     input logic [9:0] last);
    return (cnt >= first) && (cnt <= last);
  endfunction

endpackage

// File: rtl/timing_delay_line.sv
// N-stage shift register with asynchronous reset to a fixed value; keeps
// timing flags in step with the colour source latency.
module timing_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VALUE;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing master: pixel/line counters, sync and blank generation, and
// colour capture aligned to a fixed-latency colour source.
module vga_timing_gen #(
  parameter int   H_VISIBLE     = video_timing_pkg::H_VISIBLE,
  parameter int   H_FRONT       = video_timing_pkg::H_FRONT,
  parameter int   H_SYNC        = video_timing_pkg::H_SYNC,
  parameter int   H_BACK        = video_timing_pkg::H_BACK,
  parameter int   V_VISIBLE     = video_timing_pkg::V_VISIBLE,
  parameter int   V_FRONT       = video_timing_pkg::V_FRONT,
  parameter int   V_SYNC        = video_timing_pkg::V_SYNC,
  parameter int   V_BACK        = video_timing_pkg::V_BACK,
  parameter logic SYNC_ACTIVE   = 1'b0,
  parameter int   COLOR_LATENCY = 1
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  output logic [9:0]  x,
  output logic [9:0]  y,
  input  logic [23:0] color,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic        line_tick,
  output logic        vblank_tick
);
  import video_timing_pkg::*;

  localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST   = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] C_VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (C_H_TOTAL > 1024 || C_V_TOTAL > 1024) begin : g_badTotal
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (COLOR_LATENCY < 1 || COLOR_LATENCY > 4) begin : g_badLatency
    $error("vga_timing_gen: COLOR_LATENCY must be in 1..4");
  end

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic [9:0] w_hNext;
  logic [9:0] w_vNext;
  logic       w_hWrap;
  logic       r_lineTick;
  logic       r_vblankTick;
  timing_t    w_rawTiming;
  timing_t    w_dlyTiming;
  rgb888_t    r_color;

  always_comb begin
    w_hWrap = (r_hcnt == C_H_LAST);
    w_hNext = w_hWrap ? 10'd0 : r_hcnt + 10'd1;
    w_vNext = r_vcnt;
    if (w_hWrap) begin
      w_vNext = (r_vcnt == C_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end
  end

  // Ticks are decoded from the next count so they line up with x/y.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_lineTick   <= 1'b0;
      r_vblankTick <= 1'b0;
    end else begin
      r_hcnt       <= w_hNext;
      r_vcnt       <= w_vNext;
      r_lineTick   <= (w_hNext == C_H_VIS);
      r_vblankTick <= (w_hNext == 10'd0) && (w_vNext == C_V_VIS);
    end
  end

  assign w_rawTiming = '{
    hs:     in_window(r_hcnt, C_HS_FIRST, C_HS_LAST),
    vs:     in_window(r_vcnt, C_VS_FIRST, C_VS_LAST),
    active: (r_hcnt < C_H_VIS) && (r_vcnt < C_V_VIS)
  };

  timing_delay_line #(
    .WIDTH       ($bits(timing_t)),
    .DEPTH       (COLOR_LATENCY),
    .RESET_VALUE ('0)
  ) u_align (
    .i_clk  (clk_25mhz),
    .i_rst  (reset),
    .i_data (w_rawTiming),
    .o_data (w_dlyTiming)
  );

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_color <= '0;
    end else begin
      r_color <= color;
    end
  end

  assign x           = r_hcnt;
  assign y           = r_vcnt;
  assign line_tick   = r_lineTick;
  assign vblank_tick = r_vblankTick;
  assign vga_r       = w_dlyTiming.active ? r_color.r : 8'd0;
  assign vga_g       = w_dlyTiming.active ? r_color.g : 8'd0;
  assign vga_b       = w_dlyTiming.active ? r_color.b : 8'd0;
  assign vga_hsync   = w_dlyTiming.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga_vsync   = w_dlyTiming.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga_blank   = ~w_dlyTiming.active;

endmodule
